i2c_arbiter: RTL and testbench
==============================

# i2c_arbiter

Shares one `i2c_master` instance among `NREQ` independent requesters. Arbitrates pending single-byte transactions, latches the winner's address, direction, data and ack setting, and drives the master's `start`. It waits for the master to complete, then returns the read byte and a completion pulse to the winning requester. It sits between on-chip clients (sensor pollers, config loaders) and the `i2c_master` command ports.

## Interface
- `NREQ`, 4: number of requesters, 2..8.
- `IDXW`, `$clog2(NREQ)`: grant index width; derived, never overridden.
- `clk`  in  1  system clock (12 MHz nominal).
- `reset`  in  1  asynchronous, active-low reset.
- `req`  in  NREQ  per-requester transaction request; level-held until `rsp_valid`.
- `req_addr`  in  NREQ*7  packed 7-bit slave addresses; requester i uses bits [7i+6:7i].
- `req_rw`  in  NREQ  per-requester direction: 0 write, 1 read.
- `req_data`  in  NREQ*8  packed write bytes.
- `req_ack`  in  NREQ  per-requester `ack_master` value for reads.
- `gnt`  out  NREQ  one-hot; high for the whole owned transaction.
- `rsp_valid`  out  NREQ  one-hot 1-cycle completion pulse.
- `rsp_data`  out  8  byte returned by the master; valid with `rsp_valid`, held until the next completion.
- `busy`  out  1  high from grant until the cycle after `rsp_valid`.
- `m_start`  out  1  to `i2c_master.start`.
- `m_slave_addr`  out  7  to `i2c_master.slave_addr`.
- `m_rw`  out  1  to `i2c_master.rw`.
- `m_data_in`  out  8  to `i2c_master.data_in`.
- `m_ack_master`  out  1  to `i2c_master.ack_master`.
- `m_data_slave`  in  8  from `i2c_master.data_slave`.
- `m_done`  in  1  from `i2c_master.done`; treated as a level, rising edge = completion.

## Operation
- FSM states: IDLE, START, WAIT, RESP.
- **IDLE:** if any `req` bit is high, pick the winner and move to START.
  - Register the one-hot `gnt`.
  - Latch the winner's addr, rw, data and ack into the `m_*` registers.
- **START:** `m_start`=1 for exactly one cycle, then go to WAIT.
- **WAIT:** hold `m_*` and `gnt` stable. On the `m_done` rising edge (`m_done` & ~`m_done_q`), capture `m_data_slave` into `rsp_data` and go to RESP.
  - `m_done_q` is registered every cycle, so a `done` that is already high from a previous transfer does not count.
- **RESP:** `rsp_valid[g]`=1 for one cycle, `gnt` cleared, then go to IDLE.
- Request behaviour:
  - Requester inputs are sampled only in the grant cycle.
  - Dropping `req` after grant does not abort the transaction; `rsp_valid` still pulses.
  - A `req` still high in the cycle after `rsp_valid` counts as a new request.
- Write transactions also capture `m_data_slave` into `rsp_data`; clients ignore that value.
- No timeout: the master always asserts `done`, even on a slave NACK.

## Timing
- Reset values:
  - `gnt`=0, `rsp_valid`=0, `rsp_data`=8'h00, `busy`=0.
  - `m_start`=0, `m_slave_addr`=0, `m_rw`=0, `m_data_in`=0, `m_ack_master`=0.
  - state IDLE, `m_done_q`=0, rotation pointer=NREQ-1.
- Latency and throughput:
  - `req` seen high in IDLE at cycle T: `gnt` and `busy` at T+1, `m_start` at T+1 only.
  - `m_done` rising at cycle D: `rsp_valid` at D+1, IDLE at D+2.
  - Earliest next grant is at D+3; back-to-back transactions cost 3 arbiter cycles of overhead.
- All outputs are registered; there is no combinational path from `req` or `m_done` to any output.
- Simultaneous events:
  - A new `req` arriving during START/WAIT/RESP waits; arbitration happens only in IDLE.
  - `m_done` rising during START is ignored, because WAIT requires the edge to occur after `m_start`.
- Reset mid-transaction: everything returns to reset values immediately and no `rsp_valid` is issued. The master is reset by the same net.

## Configuration
- `I2C_ARB_RR_EN` defined: round-robin.
  - The search starts at pointer+1 mod NREQ.
  - The pointer updates to the granted index at grant.
  - Wrap-around from NREQ-1 goes to 0.
- Undefined: fixed priority, lowest index wins. The pointer is absent.

## Structure
- Shared package `i2c_pkg`:
  - `I2C_ADDR_W`=7, `I2C_DATA_W`=8.
  - FSM state typedef `i2c_arb_state_t` (IDLE, START, WAIT, RESP).
- Sub-module `i2c_arb_pick`: combinational rotating priority encoder.
  - Inputs: `req`, base index.
  - Outputs: one-hot and binary index.
  - Under fixed priority, base is tied to NREQ-1.

## Test plan
- **Single write:** req[1], addr 0x50, data 0xAA, rw 0.
  - `gnt`=4'b0010 next cycle; one `m_start` pulse with `m_slave_addr`=0x50, `m_data_in`=0xAA.
  - `rsp_valid[1]` one cycle after `m_done` rises.
- **Single read:** req[2], rw 1, model `m_data_slave`=0x3C.
  - `rsp_data`=0x3C with `rsp_valid[2]`; `m_ack_master` equals `req_ack[2]`.
- **Contention:** all four req held high for 8 transactions.
  - RR_EN: grant order 0,1,2,3,0,1,2,3.
  - Without RR_EN: eight grants to 0.
- **Stale done:** `m_done` held high from the previous transfer when a new grant issues.
  - No `rsp_valid` until `m_done` falls and rises again.
- **Request drop:** req[3] drops during WAIT → transaction completes, `rsp_valid[3]` still pulses.
- **Reset mid-transaction:** `reset` low during WAIT.
  - All outputs 0 asynchronously, no `rsp_valid`.
  - After release, req[0] is granted first.

Source files
------------

// File: rtl/i2c_pkg.sv
// rtl/i2c_pkg.sv - shared widths and arbiter FSM state type for the i2c block
package i2c_pkg;

  localparam int I2C_ADDR_W = 7;
  localparam int I2C_DATA_W = 8;

  typedef enum logic [1:0] {
    IDLE,
    START,
    WAIT,
    RESP
  } i2c_arb_state_t;

endpackage

// File: rtl/i2c_arb_pick.sv
// rtl/i2c_arb_pick.sv - rotating priority encoder; search starts one past base_i
module i2c_arb_pick
  import i2c_pkg::*;
#(
  parameter int NREQ = 4,
  parameter int IDXW = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] req_i,
  input  logic [IDXW-1:0] base_i,
  output logic [NREQ-1:0] onehot_o,
  output logic [IDXW-1:0] idx_o
);

  logic            found;
  logic [IDXW-1:0] k;

  always_comb begin
    onehot_o = '0;
    idx_o    = '0;
    found    = 1'b0;
    k        = '0;
    for (int i = 1; i <= NREQ; i++) begin
      k = IDXW'((int'(base_i) + i) % NREQ);
      if (!found && req_i[k]) begin
        found       = 1'b1;
        onehot_o[k] = 1'b1;
        idx_o       = k;
      end
    end
  end

endmodule

// File: rtl/i2c_arbiter.sv
// rtl/i2c_arbiter.sv - shares one i2c_master among NREQ requesters
// I2C_ARB_RR_EN selects round-robin arbitration; otherwise lowest index wins.
module i2c_arbiter
  import i2c_pkg::*;
#(
  parameter int NREQ = 4
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [NREQ-1:0]            req,
  input  logic [NREQ*I2C_ADDR_W-1:0] req_addr,
  input  logic [NREQ-1:0]            req_rw,
  input  logic [NREQ*I2C_DATA_W-1:0] req_data,
  input  logic [NREQ-1:0]            req_ack,
  output logic [NREQ-1:0]            gnt,
  output logic [NREQ-1:0]            rsp_valid,
  output logic [I2C_DATA_W-1:0]      rsp_data,
  output logic                       busy,
  output logic                       m_start,
  output logic [I2C_ADDR_W-1:0]      m_slave_addr,
  output logic                       m_rw,
  output logic [I2C_DATA_W-1:0]      m_data_in,
  output logic                       m_ack_master,
  input  logic [I2C_DATA_W-1:0]      m_data_slave,
  input  logic                       m_done
);

  localparam int IDXW = $clog2(NREQ);

  i2c_arb_state_t        state_q;
  logic [NREQ-1:0]       gnt_q;
  logic [NREQ-1:0]       rsp_valid_q;
  logic [I2C_DATA_W-1:0] rsp_data_q;
  logic                  busy_q;
  logic                  m_start_q;
  logic [I2C_ADDR_W-1:0] m_addr_q;
  logic                  m_rw_q;
  logic [I2C_DATA_W-1:0] m_data_q;
  logic                  m_ack_q;
  logic                  m_done_q;

  logic [IDXW-1:0]       base_d;
  logic [NREQ-1:0]       pick_oh_d;
  logic [IDXW-1:0]       pick_idx_d;
  logic [I2C_ADDR_W-1:0] win_addr_d;
  logic [I2C_DATA_W-1:0] win_data_d;
  logic                  win_rw_d;
  logic                  win_ack_d;

`ifdef I2C_ARB_RR_EN
  logic [IDXW-1:0] ptr_q;
  assign base_d = ptr_q;
`else
  assign base_d = IDXW'(NREQ - 1);
`endif

  i2c_arb_pick #(
    .NREQ (NREQ),
    .IDXW (IDXW)
  ) u_pick (
    .req_i    (req),
    .base_i   (base_d),
    .onehot_o (pick_oh_d),
    .idx_o    (pick_idx_d)
  );

  assign win_addr_d = req_addr[int'(pick_idx_d)*I2C_ADDR_W +: I2C_ADDR_W];
  assign win_data_d = req_data[int'(pick_idx_d)*I2C_DATA_W +: I2C_DATA_W];
  assign win_rw_d   = req_rw[pick_idx_d];
  assign win_ack_d  = req_ack[pick_idx_d];

  // Requester inputs are looked at only in IDLE; afterwards m_* stay latched.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= IDLE;
      gnt_q       <= '0;
      rsp_valid_q <= '0;
      rsp_data_q  <= '0;
      busy_q      <= 1'b0;
      m_start_q   <= 1'b0;
      m_addr_q    <= '0;
      m_rw_q      <= 1'b0;
      m_data_q    <= '0;
      m_ack_q     <= 1'b0;
      m_done_q    <= 1'b0;
`ifdef I2C_ARB_RR_EN
      ptr_q       <= IDXW'(NREQ - 1);
`endif
    end else begin
      m_done_q <= m_done;
      case (state_q)
        IDLE: begin
          if (|req) begin
            gnt_q     <= pick_oh_d;
            busy_q    <= 1'b1;
            m_start_q <= 1'b1;
            m_addr_q  <= win_addr_d;
            m_rw_q    <= win_rw_d;
            m_data_q  <= win_data_d;
            m_ack_q   <= win_ack_d;
`ifdef I2C_ARB_RR_EN
            ptr_q     <= pick_idx_d;
`endif
            state_q   <= START;
          end
        end
        START: begin
          m_start_q <= 1'b0;
          state_q   <= WAIT;
        end
        WAIT: begin
          // Only a fresh rising edge counts; a done left high is stale.
          if (m_done && !m_done_q) begin
            rsp_data_q  <= m_data_slave;
            rsp_valid_q <= gnt_q;
            state_q     <= RESP;
          end
        end
        RESP: begin
          rsp_valid_q <= '0;
          gnt_q       <= '0;
          busy_q      <= 1'b0;
          state_q     <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign gnt          = gnt_q;
  assign rsp_valid    = rsp_valid_q;
  assign rsp_data     = rsp_data_q;
  assign busy         = busy_q;
  assign m_start      = m_start_q;
  assign m_slave_addr = m_addr_q;
  assign m_rw         = m_rw_q;
  assign m_data_in    = m_data_q;
  assign m_ack_master = m_ack_q;

endmodule

// File: tb/tb_i2c_arbiter.sv
// tb/tb_i2c_arbiter.sv - directed scoreboard bench for i2c_arbiter
module tb_i2c_arbiter;

  localparam int NREQ = 4;

  logic              clk;
  logic              reset;
  logic [NREQ-1:0]   req;
  logic [NREQ*7-1:0] req_addr;
  logic [NREQ-1:0]   req_rw;
  logic [NREQ*8-1:0] req_data;
  logic [NREQ-1:0]   req_ack;
  logic [NREQ-1:0]   gnt;
  logic [NREQ-1:0]   rsp_valid;
  logic [7:0]        rsp_data;
  logic              busy;
  logic              m_start;
  logic [6:0]        m_slave_addr;
  logic              m_rw;
  logic [7:0]        m_data_in;
  logic              m_ack_master;
  logic [7:0]        m_data_slave;
  logic              m_done;

  i2c_arbiter #(.NREQ(NREQ)) dut (
    .clk          (clk),
    .reset        (reset),
    .req          (req),
    .req_addr     (req_addr),
    .req_rw       (req_rw),
    .req_data     (req_data),
    .req_ack      (req_ack),
    .gnt          (gnt),
    .rsp_valid    (rsp_valid),
    .rsp_data     (rsp_data),
    .busy         (busy),
    .m_start      (m_start),
    .m_slave_addr (m_slave_addr),
    .m_rw         (m_rw),
    .m_data_in    (m_data_in),
    .m_ack_master (m_ack_master),
    .m_data_slave (m_data_slave),
    .m_done       (m_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int         idx;
    logic [6:0] addr;
    logic       rw;
    logic [7:0] data;
    logic       ack;
    logic [7:0] sd;
  } exp_t;

  exp_t sb[$];
  int   vectors = 0;
  int   miscompares = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [NREQ-1:0] oh(input int i);
    logic [NREQ-1:0] one;
    one = 1;
    return one << i;
  endfunction

  task automatic check_all_zero(input string tag);
    check({tag, "_gnt"},  32'(gnt), 0);
    check({tag, "_rspv"}, 32'(rsp_valid), 0);
    check({tag, "_rspd"}, 32'(rsp_data), 0);
    check({tag, "_busy"}, 32'(busy), 0);
    check({tag, "_mst"},  32'(m_start), 0);
    check({tag, "_madr"}, 32'(m_slave_addr), 0);
    check({tag, "_mrw"},  32'(m_rw), 0);
    check({tag, "_mdat"}, 32'(m_data_in), 0);
    check({tag, "_mack"}, 32'(m_ack_master), 0);
  endtask

  task automatic set_slot(input int i, input logic [6:0] a, input logic rw,
                          input logic [7:0] d, input logic ack);
    req_addr[i*7 +: 7] = a;
    req_data[i*8 +: 8] = d;
    req_rw[i]          = rw;
    req_ack[i]         = ack;
  endtask

  task automatic push_exp(input int i, input logic [6:0] a, input logic rw,
                          input logic [7:0] d, input logic ack, input logic [7:0] sd);
    exp_t e;
    e.idx = i; e.addr = a; e.rw = rw; e.data = d; e.ack = ack; e.sd = sd;
    sb.push_back(e);
  endtask

  // Plays the master side of one transaction and checks it against the scoreboard head.
  task automatic txn(input bit drop, input bit clear_rsp, input bit keep_done);
    exp_t e;
    int   cnt;
    bit   seen;
    if (sb.size() == 0) begin
      check("sb_empty", 1, 0);
      return;
    end
    e = sb.pop_front();
    seen = 0;
    cnt  = 0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      cnt++;
      if (m_start === 1'b1) begin
        seen = 1;
        break;
      end
    end
    check("start_seen", 32'(seen), 1);
    if (!seen) return;
    check("grant_latency", cnt, 1);
    check("gnt", 32'(gnt), 32'(oh(e.idx)));
    check("busy_on", 32'(busy), 1);
    check("m_addr", 32'(m_slave_addr), 32'(e.addr));
    check("m_rw", 32'(m_rw), 32'(e.rw));
    check("m_data", 32'(m_data_in), 32'(e.data));
    check("m_ack", 32'(m_ack_master), 32'(e.ack));
    @(negedge clk);
    check("start_one_cycle", 32'(m_start), 0);
    check("gnt_hold", 32'(gnt), 32'(oh(e.idx)));
    if (drop) req[e.idx] = 1'b0;
    if (m_done) begin
      for (int c = 0; c < 3; c++) begin
        @(negedge clk);
        check("stale_no_rsp", 32'(rsp_valid), 0);
      end
      m_done = 1'b0;
      @(negedge clk);
      check("stale_no_rsp_low", 32'(rsp_valid), 0);
    end else begin
      @(negedge clk);
      check("no_early_rsp", 32'(rsp_valid), 0);
    end
    m_data_slave = e.sd;
    m_done = 1'b1;
    @(negedge clk);
    check("rsp_valid", 32'(rsp_valid), 32'(oh(e.idx)));
    check("rsp_data", 32'(rsp_data), 32'(e.sd));
    check("m_addr_held", 32'(m_slave_addr), 32'(e.addr));
    if (!keep_done) m_done = 1'b0;
    if (clear_rsp) req = '0;
    @(negedge clk);
    check("rsp_pulse_end", 32'(rsp_valid), 0);
    check("busy_off", 32'(busy), 0);
    check("gnt_off", 32'(gnt), 0);
    check("rsp_data_held", 32'(rsp_data), 32'(e.sd));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b0;
    req = '0; req_addr = '0; req_rw = '0; req_data = '0; req_ack = '0;
    m_data_slave = 8'h00; m_done = 1'b0;
    repeat (2) @(negedge clk);
    check_all_zero("reset");
    reset = 1'b1;
    @(negedge clk);

    // Single write from requester 1
    set_slot(1, 7'h50, 1'b0, 8'hAA, 1'b0);
    push_exp(1, 7'h50, 1'b0, 8'hAA, 1'b0, 8'h5A);
    req[1] = 1'b1;
    txn(1'b1, 1'b0, 1'b0);

    // Single read from requester 2
    set_slot(2, 7'h21, 1'b1, 8'h00, 1'b1);
    push_exp(2, 7'h21, 1'b1, 8'h00, 1'b1, 8'h3C);
    req[2] = 1'b1;
    txn(1'b1, 1'b0, 1'b0);

    // Contention from a fresh reset so the rotation pointer starts at NREQ-1
    reset = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    for (int i = 0; i < NREQ; i++)
      set_slot(i, 7'(8'h10 + i), i[0], 8'(8'hA0 + i), i[1]);
    for (int t = 0; t < 8; t++) begin
`ifdef I2C_ARB_RR_EN
      int w = t % NREQ;
`else
      int w = 0;
`endif
      push_exp(w, 7'(8'h10 + w), w[0], 8'(8'hA0 + w), w[1], 8'(8'hC0 + t));
    end
    req = '1;
    for (int t = 0; t < 8; t++) txn(1'b0, t == 7, 1'b0);

    // Stale done: first transfer leaves done high into the next grant
    set_slot(0, 7'h33, 1'b1, 8'h11, 1'b0);
    push_exp(0, 7'h33, 1'b1, 8'h11, 1'b0, 8'h77);
    req[0] = 1'b1;
    txn(1'b1, 1'b0, 1'b1);
    push_exp(0, 7'h33, 1'b1, 8'h11, 1'b0, 8'h88);
    req[0] = 1'b1;
    txn(1'b1, 1'b0, 1'b0);

    // Requester 3 drops req during WAIT
    set_slot(3, 7'h7F, 1'b0, 8'hE5, 1'b1);
    push_exp(3, 7'h7F, 1'b0, 8'hE5, 1'b1, 8'h42);
    req[3] = 1'b1;
    txn(1'b1, 1'b0, 1'b0);

    // Asynchronous reset while requester 1 waits for done
    req[1] = 1'b1;
    @(negedge clk);
    check("rst_mid_start", 32'(m_start), 1);
    @(negedge clk);
    req[0] = 1'b1;
    #2 reset = 1'b0;
    #1 check_all_zero("rst_mid");
    @(negedge clk);
    check("rst_mid_no_rsp", 32'(rsp_valid), 0);
    set_slot(0, 7'h0C, 1'b0, 8'h5E, 1'b1);
    push_exp(0, 7'h0C, 1'b0, 8'h5E, 1'b1, 8'h99);
    reset = 1'b1;
    txn(1'b0, 1'b1, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
